cvxif_offload_scheduler: RTL and testbench

//  Sequences offloaded CV-X-IF instructions onto a single shared multi-cycle coprocessor execution unit.

---
 rtl/cvxif_offload_scheduler.sv | 139 +++++++++++++
 tb/tb_cvxif_offload_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_offload_scheduler.sv
// In-order queue for offloaded CV-X-IF ops: commit/kill resolved per entry, one op at a time on a shared exec unit.
// Issue+commit in cycle 0 -> exec_valid in cycle 2; exec/result channels hold until accepted, issue_ready drops when full.
module cvxif_offload_scheduler #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 3,
    parameter int DATA_W = 192,
    parameter int XLEN   = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [ID_W-1:0]   issue_id_i,
    input  logic [DATA_W-1:0] issue_data_i,
    input  logic              commit_valid_i,
    input  logic [ID_W-1:0]   commit_id_i,
    input  logic              commit_kill_i,
    output logic              exec_valid_o,
    input  logic              exec_ready_i,
    output logic [ID_W-1:0]   exec_id_o,
    output logic [DATA_W-1:0] exec_data_o,
    input  logic              exec_done_i,
    input  logic [XLEN-1:0]   exec_result_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [ID_W-1:0]   result_id_o,
    output logic [XLEN-1:0]   result_data_o,
    output logic              busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {E_EMPTY, E_ISSUED, E_COMMITTED, E_KILLED} ent_st_t;
    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_RESP} fsm_t;

    ent_st_t           r_st   [DEPTH];
    logic [ID_W-1:0]   r_id   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    fsm_t              r_fsm;
    fsm_t              w_fsm_nxt;
    logic [ID_W-1:0]   r_res_id;
    logic [XLEN-1:0]   r_res_data;

    logic    w_push;
    logic    w_pop;
    ent_st_t w_head_st;
    ent_st_t w_commit_st;

    assign issue_ready_o = (r_count < CNT_W'(DEPTH));
    assign w_push        = issue_valid_i & issue_ready_o;
    assign w_head_st     = r_st[r_head];
    assign w_commit_st   = commit_kill_i ? E_KILLED : E_COMMITTED;

    // A killed head retires without touching the exec unit; a served head retires on result handshake.
    assign w_pop = ((r_fsm == S_IDLE) && (w_head_st == E_KILLED)) ||
                   ((r_fsm == S_RESP) && result_ready_i);

    assign exec_id_o     = r_id[r_head];
    assign exec_data_o   = r_data[r_head];
    assign result_id_o   = r_res_id;
    assign result_data_o = r_res_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:     if (w_head_st == E_COMMITTED) w_fsm_nxt = S_DISPATCH;
            S_DISPATCH: if (exec_ready_i)             w_fsm_nxt = S_WAIT;
            S_WAIT:     if (exec_done_i)              w_fsm_nxt = S_RESP;
            S_RESP:     if (result_ready_i)           w_fsm_nxt = S_IDLE;
            default:                                  w_fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        exec_valid_o   = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = (r_count != '0) || (r_fsm != S_IDLE);
        case (r_fsm)
            S_DISPATCH: exec_valid_o   = 1'b1;
            S_RESP:     result_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Only ISSUED entries can match, so a kill aimed at a head already in flight is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i] <= E_EMPTY;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && (r_st[i] == E_ISSUED) && (r_id[i] == commit_id_i)) begin
                    r_st[i] <= w_commit_st;
                end
            end
            if (w_pop) begin
                r_st[r_head] <= E_EMPTY;
                r_head       <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_st[r_tail] <= (commit_valid_i && (commit_id_i == issue_id_i)) ? w_commit_st : E_ISSUED;
                r_tail       <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id[r_tail]   <= issue_id_i;
            r_data[r_tail] <= issue_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_id   <= '0;
            r_res_data <= '0;
        end else if ((r_fsm == S_WAIT) && exec_done_i) begin
            r_res_id   <= r_id[r_head];
            r_res_data <= exec_result_i;
        end
    end
endmodule

// File: tb/tb_cvxif_offload_scheduler.sv
// Bench for cvxif_offload_scheduler: vector table, directed corner sequences, random traffic vs a queue model.
module tb_cvxif_offload_scheduler;
    localparam int DEPTH = 4, ID_W = 3, DATA_W = 192, XLEN = 64;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic              issue_ready_o;
    logic [ID_W-1:0]   issue_id_i = '0;
    logic [DATA_W-1:0] issue_data_i = '0;
    logic              commit_valid_i = 1'b0;
    logic [ID_W-1:0]   commit_id_i = '0;
    logic              commit_kill_i = 1'b0;
    logic              exec_valid_o;
    logic              exec_ready_i = 1'b0;
    logic [ID_W-1:0]   exec_id_o;
    logic [DATA_W-1:0] exec_data_o;
    logic              exec_done_i = 1'b0;
    logic [XLEN-1:0]   exec_result_i = '0;
    logic              result_valid_o;
    logic              result_ready_i = 1'b0;
    logic [ID_W-1:0]   result_id_o;
    logic [XLEN-1:0]   result_data_o;
    logic              busy_o;

    cvxif_offload_scheduler #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_data_i(issue_data_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i),
        .exec_id_o(exec_id_o), .exec_data_o(exec_data_o),
        .exec_done_i(exec_done_i), .exec_result_i(exec_result_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] opnd(input logic [ID_W-1:0] id);
        return {64'h3333_0000 + 64'(id), 64'h2222_0000 + 64'(id), 64'h1111_0000 + 64'(id)};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit iv; logic [2:0] iid; bit cv; logic [2:0] cid; bit ck; bit ed; logic [63:0] eres;
        bit x_ir; bit x_ev; logic [2:0] x_eid; bit x_rv; logic [2:0] x_rid; logic [63:0] x_rdat; bit x_busy;
    } vec_t;

    function automatic vec_t mkv(input bit iv, input int iid, input bit cv, input int cid, input bit ck,
                                 input bit ed, input logic [63:0] eres, input bit x_ir, input bit x_ev,
                                 input int x_eid, input bit x_rv, input int x_rid, input logic [63:0] x_rdat,
                                 input bit x_busy);
        vec_t v;
        v.iv = iv; v.iid = 3'(iid); v.cv = cv; v.cid = 3'(cid); v.ck = ck; v.ed = ed; v.eres = eres;
        v.x_ir = x_ir; v.x_ev = x_ev; v.x_eid = 3'(x_eid); v.x_rv = x_rv; v.x_rid = 3'(x_rid);
        v.x_rdat = x_rdat; v.x_busy = x_busy;
        return v;
    endfunction

    // ---------------- reference model ----------------
    localparam int ST_ISSUED = 0, ST_COMMIT = 1, ST_KILL = 2;
    localparam int U_FREE = 0, U_OFFER = 1, U_RUN = 2, U_RET = 3;
    typedef struct { logic [2:0] id; logic [DATA_W-1:0] data; int st; } ent_t;

    ent_t        mq[$];
    int          m_unit = U_FREE;
    logic [2:0]  m_rid  = '0;
    logic [63:0] m_rdat = '0;
    int          disp_ids[$];

    task automatic model_reset();
        mq.delete();
        m_unit = U_FREE;
        m_rid  = '0;
        m_rdat = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        issue_valid_i = 1'b0; commit_valid_i = 1'b0; exec_done_i = 1'b0;
        exec_ready_i = 1'b1; result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // Drive one cycle, compare every output against the model, then advance the model over the edge.
    task automatic step(input bit iv = 0, input logic [2:0] iid = 0, input logic [DATA_W-1:0] idat = '0,
                        input bit cv = 0, input logic [2:0] cid = 0, input bit ck = 0,
                        input bit er = 1, input bit ed = 0, input logic [63:0] eres = 0, input bit rr = 1);
        bit x_ready, x_ev, x_rv, x_busy, do_pop;
        ent_t e;
        issue_valid_i = iv; issue_id_i = iid; issue_data_i = idat ^ opnd(iid);
        commit_valid_i = cv; commit_id_i = cid; commit_kill_i = ck;
        exec_ready_i = er; exec_done_i = ed; exec_result_i = eres; result_ready_i = rr;
        #4;
        x_ready = (mq.size() < DEPTH);
        x_ev    = (m_unit == U_OFFER);
        x_rv    = (m_unit == U_RET);
        x_busy  = (mq.size() != 0) || (m_unit != U_FREE);
        chk("issue_ready", issue_ready_o, x_ready);
        chk("exec_valid", exec_valid_o, x_ev);
        chk("result_valid", result_valid_o, x_rv);
        chk("result_id", result_id_o, m_rid);
        chk("result_data", result_data_o, m_rdat);
        chk("busy", busy_o, x_busy);
        if (x_ev) begin
            chk("exec_id", exec_id_o, mq[0].id);
            chk("exec_data", exec_data_o, mq[0].data);
        end
        if (exec_valid_o && er) disp_ids.push_back(int'(exec_id_o));
        do_pop = 0;
        case (m_unit)
            U_FREE: if (mq.size() > 0) begin
                if (mq[0].st == ST_KILL) do_pop = 1;
                else if (mq[0].st == ST_COMMIT) m_unit = U_OFFER;
            end
            U_OFFER: if (er) m_unit = U_RUN;
            U_RUN: if (ed) begin m_unit = U_RET; m_rid = mq[0].id; m_rdat = eres; end
            U_RET: if (rr) begin do_pop = 1; m_unit = U_FREE; end
            default: ;
        endcase
        if (cv) foreach (mq[i]) if (mq[i].st == ST_ISSUED && mq[i].id == cid) mq[i].st = ck ? ST_KILL : ST_COMMIT;
        if (iv && x_ready) begin
            e.id = iid; e.data = idat ^ opnd(iid);
            e.st = (cv && cid == iid) ? (ck ? ST_KILL : ST_COMMIT) : ST_ISSUED;
            mq.push_back(e);
        end
        if (do_pop) void'(mq.pop_front());
        @(posedge clk_i); #1;
    endtask

    initial begin
        vec_t        tv[15];
        logic [2:0]  r_iid, r_cid;
        bit          r_iv, r_cv;
        logic [DATA_W-1:0] r_dat;

        tv[0]  = mkv(1,2, 1,2,0, 0,0,     1,0,0, 0,0,0,     0);
        tv[1]  = mkv(0,0, 0,0,0, 0,0,     1,0,0, 0,0,0,     1);
        tv[2]  = mkv(0,0, 0,0,0, 0,0,     1,1,2, 0,0,0,     1);
        tv[3]  = mkv(0,0, 0,0,0, 0,0,     1,0,0, 0,0,0,     1);
        tv[4]  = mkv(0,0, 0,0,0, 1,'h15,  1,0,0, 0,0,0,     1);
        tv[5]  = mkv(0,0, 0,0,0, 0,0,     1,0,0, 1,2,'h15,  1);
        tv[6]  = mkv(0,0, 0,0,0, 0,0,     1,0,0, 0,2,'h15,  0);
        tv[7]  = mkv(1,1, 0,0,0, 0,0,     1,0,0, 0,2,'h15,  0);
        tv[8]  = mkv(1,2, 1,1,1, 0,0,     1,0,0, 0,2,'h15,  1);
        tv[9]  = mkv(0,0, 1,2,0, 0,0,     1,0,0, 0,2,'h15,  1);
        tv[10] = mkv(0,0, 0,0,0, 0,0,     1,0,0, 0,2,'h15,  1);
        tv[11] = mkv(0,0, 0,0,0, 0,0,     1,1,2, 0,2,'h15,  1);
        tv[12] = mkv(0,0, 0,0,0, 1,'h99,  1,0,0, 0,2,'h15,  1);
        tv[13] = mkv(0,0, 0,0,0, 0,0,     1,0,0, 1,2,'h99,  1);
        tv[14] = mkv(0,0, 0,0,0, 0,0,     1,0,0, 0,2,'h99,  0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            issue_valid_i = tv[i].iv; issue_id_i = tv[i].iid; issue_data_i = opnd(tv[i].iid);
            commit_valid_i = tv[i].cv; commit_id_i = tv[i].cid; commit_kill_i = tv[i].ck;
            exec_ready_i = 1'b1; exec_done_i = tv[i].ed; exec_result_i = tv[i].eres; result_ready_i = 1'b1;
            #4;
            chk($sformatf("tv%0d issue_ready", i), issue_ready_o, tv[i].x_ir);
            chk($sformatf("tv%0d exec_valid", i), exec_valid_o, tv[i].x_ev);
            if (tv[i].x_ev) begin
                chk($sformatf("tv%0d exec_id", i), exec_id_o, tv[i].x_eid);
                chk($sformatf("tv%0d exec_data", i), exec_data_o, opnd(tv[i].x_eid));
            end
            chk($sformatf("tv%0d result_valid", i), result_valid_o, tv[i].x_rv);
            chk($sformatf("tv%0d result_id", i), result_id_o, tv[i].x_rid);
            chk($sformatf("tv%0d result_data", i), result_data_o, tv[i].x_rdat);
            chk($sformatf("tv%0d busy", i), busy_o, tv[i].x_busy);
            @(posedge clk_i); #1;
        end

        // Full queue: ready drops, stays low through the pop cycle, rises the cycle after.
        do_reset();
        for (int i = 0; i < 4; i++) step(.iv(1), .iid(3'(i)));
        chk("full ready", issue_ready_o, 1'b0);
        step(.iv(1), .iid(3'd4));
        step(.cv(1), .cid(3'd0));
        step();
        step();
        step(.ed(1), .eres(64'hC0DE));
        chk("full ready in resp", issue_ready_o, 1'b0);
        step(.rr(1));
        chk("full ready after pop", issue_ready_o, 1'b1);

        // Out-of-order commits still dispatch in issue order.
        do_reset();
        disp_ids.delete();
        for (int i = 0; i < 3; i++) step(.iv(1), .iid(3'(i)));
        for (int i = 2; i >= 0; i--) step(.cv(1), .cid(3'(i)), .ed(1), .eres(64'(100 + i)));
        for (int i = 0; i < 12; i++) step(.ed(1), .eres(64'(200 + i)));
        chk("ooo count", disp_ids.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("ooo order %0d", i), (i < disp_ids.size()) ? disp_ids[i] : -1, i);

        // Backpressure on both channels.
        step(.iv(1), .iid(3'd5), .cv(1), .cid(3'd5), .er(0));
        step(.er(0));
        for (int i = 0; i < 3; i++) begin
            chk("bp exec_valid", exec_valid_o, 1'b1);
            chk("bp exec_id", exec_id_o, 3'd5);
            chk("bp exec_data", exec_data_o, opnd(3'd5));
            step(.er(0));
        end
        step(.er(1));
        step(.ed(1), .eres(64'hBEEF), .rr(0));
        for (int i = 0; i < 3; i++) begin
            chk("bp result_valid", result_valid_o, 1'b1);
            chk("bp result_id", result_id_o, 3'd5);
            chk("bp result_data", result_data_o, 64'hBEEF);
            chk("bp busy", busy_o, 1'b1);
            step(.rr(0));
        end
        step(.rr(1));
        chk("bp done busy", busy_o, 1'b0);

        // Reset while waiting on the exec unit; a late done must not produce a result.
        step(.iv(1), .iid(3'd6), .cv(1), .cid(3'd6));
        step();
        step();
        do_reset();
        chk("rst busy", busy_o, 1'b0);
        chk("rst issue_ready", issue_ready_o, 1'b1);
        step(.ed(1), .eres(64'h77));
        for (int i = 0; i < 3; i++) step();
        chk("rst no result", result_valid_o, 1'b0);
        chk("rst result_data", result_data_o, 64'h0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(699) == 0) do_reset();
            r_iid = 3'($urandom_range(7));
            r_iv  = ($urandom_range(3) != 0);
            foreach (mq[i]) if (mq[i].id == r_iid) r_iv = 0;
            r_cv  = ($urandom_range(2) == 0);
            r_cid = 3'($urandom_range(7));
            if (mq.size() > 0 && $urandom_range(1) == 0) r_cid = mq[$urandom_range(mq.size() - 1)].id;
            r_dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(.iv(r_iv), .iid(r_iid), .idat(r_dat), .cv(r_cv), .cid(r_cid), .ck($urandom_range(3) == 0),
                 .er($urandom_range(3) != 0), .ed($urandom_range(2) == 0),
                 .eres({$urandom, $urandom}), .rr($urandom_range(3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
